// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: W-bit add/subtract performed nibble-serially through a
// single 4-bit adder/subtractor, LSB nibble first, under IDLE/RUN/DONE control.
module addsub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 co,
  output logic                 v
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             mode_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     shadow;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       nib_sum;
  logic             nib_co;
  logic [3:0]       low_sum;
  logic             msb_cin;
  logic             last_pass;
  logic [W-1:0]     shadow_merged;

  // Nibble adder: B is inverted in subtract mode, with the initial carry = mode
  // supplying the +1. The carry into bit 3 of the final nibble is the carry
  // into the word MSB, which together with the carry out gives signed overflow.
  always_comb begin
    a_nib         = a_reg[{idx, 2'b00} +: 4];
    b_nib         = b_reg[{idx, 2'b00} +: 4] ^ {4{mode_reg}};
    {nib_co, nib_sum} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    low_sum       = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};
    msb_cin       = low_sum[3];
    last_pass     = (idx == LAST_IDX);
    shadow_merged = shadow;
    shadow_merged[{idx, 2'b00} +: 4] = nib_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs; busy covers RUN and DONE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_pass) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, one nibble per RUN cycle, and publish
  // sum/co/v on the final pass so they appear together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      mode_reg <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      shadow   <= '0;
      sum      <= '0;
      co       <= 1'b0;
      v        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            mode_reg <= mode;
            idx      <= '0;
            carry    <= mode;
          end
        end
        RUN: begin
          shadow <= shadow_merged;
          carry  <= nib_co;
          idx    <= idx + 1'b1;
          if (last_pass) begin
            sum <= shadow_merged;
            co  <= nib_co;
            v   <= nib_co ^ msb_cin;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_addsub_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        co;
  logic        v;

  int checks;
  int errors;
  int cycle_count;
  int last_done;

  logic [15:0] prev_sum;
  logic        prev_co;
  logic        prev_v;

  addsub_seq_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
    .v     (v)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure done spacing.
  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  task automatic modelResult(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_mode,
                             output logic [15:0] r_sum, output logic r_co, output logic r_v);
    int unsigned ua;
    int unsigned ub;
    int unsigned t;
    int sa;
    int sb;
    int r;
    ua = 32'(op_a);
    ub = 32'(op_b);
    sa = int'($signed(op_a));
    sb = int'($signed(op_b));
    if (op_mode) begin
      t    = ua - ub;
      r_co = (ua >= ub);
      r    = sa - sb;
    end else begin
      t    = ua + ub;
      r_co = (t > 32'hFFFF);
      r    = sa + sb;
    end
    r_sum = t[15:0];
    r_v   = (r > 32767) || (r < -32768);
  endtask

  // One operation: drive start at a negedge in IDLE, then check each of the
  // following cycles. style: 0 quiet, 1 random garbage incl. start,
  // 2 foreign start pulse in RUN cycle 2, 3 start held high.
  task automatic applyStimulus(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_mode,
                               input int style, input bit check_spacing);
    logic [15:0] es;
    logic        ec;
    logic        ev;
    modelResult(op_a, op_b, op_mode, es, ec, ev);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    mode  = op_mode;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("done", 32'(done), (c == 5) ? 32'd1 : 32'd0);
      if (c < 5) begin
        checkOutput("hold_sum", 32'(sum), 32'(prev_sum));
        checkOutput("hold_cov", {30'd0, co, v}, {30'd0, prev_co, prev_v});
      end else begin
        checkOutput("sum", 32'(sum), 32'(es));
        checkOutput("co", 32'(co), 32'(ec));
        checkOutput("v", 32'(v), 32'(ev));
        if (check_spacing) begin
          checkOutput("done_spacing", 32'(cycle_count - last_done), 32'd6);
        end
        last_done = cycle_count;
      end
      a    = 16'($urandom);
      b    = 16'($urandom);
      mode = 1'($urandom);
      case (style)
        1: start = 1'($urandom);
        2: begin
          start = (c == 2);
          if (c == 2) begin
            a    = 16'hFFFF;
            b    = 16'hFFFF;
            mode = 1'b1;
          end
        end
        3: start = 1'b1;
        default: start = 1'b0;
      endcase
    end
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_sum", 32'(sum), 32'(es));
    start    = 1'b0;
    prev_sum = es;
    prev_co  = ec;
    prev_v   = ev;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cycle_count = 0;
    last_done   = 0;
    prev_sum    = '0;
    prev_co     = 1'b0;
    prev_v      = 1'b0;
    rst_n       = 1'b1;
    start       = 1'b0;
    mode        = 1'b0;
    a           = '0;
    b           = '0;

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_co", 32'(co), 32'd0);
    checkOutput("rst_v", 32'(v), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    applyStimulus(16'h1234, 16'h0FFF, 1'b0, 0, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 0, 1'b1);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 0, 1'b1);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 2, 1'b1);
    applyStimulus(16'h1000, 16'h7000, 1'b0, 1, 1'b1);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 0, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 0, 1'b1);

    // Reset during RUN with idx = 2 aborts the operation.
    start = 1'b1;
    a     = 16'h4321;
    b     = 16'h1111;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_co", 32'(co), 32'd0);
    checkOutput("abort_v", 32'(v), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post_abort_done", 32'(done), 32'd0);
      checkOutput("post_abort_sum", {15'd0, co, v, sum}, 32'd0);
    end
    prev_sum = '0;
    prev_co  = 1'b0;
    prev_v   = 1'b0;
    applyStimulus(16'h4321, 16'h1111, 1'b1, 0, 1'b0);

    // start held high for three back-to-back operations.
    applyStimulus(16'hABCD, 16'h1357, 1'b0, 3, 1'b1);
    applyStimulus(16'h0F0F, 16'hF0F0, 1'b1, 3, 1'b1);
    applyStimulus(16'h7FFE, 16'h0003, 1'b0, 3, 1'b1);

    // Random operations with random interference on the inputs.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
